// File: rtl/decoder_seq_n.sv
// rtl/decoder_seq_n.sv - registered select-code decoder with one-hot, thermometer, one-cold and timed-pulse modes
module decoder_seq_n #(
    parameter int IN_W     = 4,
    parameter int OUT_W    = 2**IN_W,
    parameter int HOLD_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  d_in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] y_out,
    output logic             out_valid
);

    localparam int CW = $clog2(HOLD_CYC + 1);

    localparam logic [1:0] MODE_ONEHOT  = 2'd0;
    localparam logic [1:0] MODE_THERM   = 2'd1;
    localparam logic [1:0] MODE_PULSE   = 2'd2;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            expire;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;
    logic [OUT_W-1:0] dec;

    assign in_ready = en && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign expire   = (state == HOLD) && (cnt == CW'(1));

    always_comb begin
        onehot = '0;
        therm  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (IN_W'(i) == d_in);
            therm[i]  = (IN_W'(i) <= d_in);
        end
        case (mode)
            MODE_ONEHOT: dec = onehot;
            MODE_THERM:  dec = therm;
            MODE_PULSE:  dec = onehot;
            default:     dec = ~onehot;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept && (mode == MODE_PULSE)) state_nxt = HOLD;
                HOLD: if (expire) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Disable wins over everything, including a pending accept or an expiring pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out     <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else if (!en) begin
            y_out     <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            y_out     <= dec;
            out_valid <= 1'b1;
            cnt       <= (mode == MODE_PULSE) ? CW'(HOLD_CYC) : '0;
        end else begin
            out_valid <= 1'b0;
            if (state == HOLD) begin
                cnt <= cnt - CW'(1);
                if (expire) begin
                    y_out <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decoder_seq_n.sv
// tb/tb_decoder_seq_n.sv - randomized and directed self-checking bench for decoder_seq_n
module tb_decoder_seq_n;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  d_in = 4'd0;
    logic [2:0]  d_in3 = 3'd0;
    logic        in_ready, out_valid, in_ready3, out_valid3;
    logic [15:0] y_out;
    logic [7:0]  y_out3;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected output, strobe and remaining pulse cycles.
    longint m_y;
    bit     m_ov;
    int     m_hold;

    always #5 clk = ~clk;

    decoder_seq_n #(.IN_W(4), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .y_out(y_out), .out_valid(out_valid)
    );

    decoder_seq_n #(.IN_W(3), .HOLD_CYC(HOLD)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in3), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready3), .y_out(y_out3), .out_valid(out_valid3)
    );

    function automatic longint decode(input int md, input int d);
        longint one;
        one = longint'(1) << d;
        case (md)
            0, 2:    return one;
            1:       return (one << 1) - 1;
            default: return (~one) & 64'hFFFF;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_y = 0; m_ov = 0; m_hold = 0;
        end else if (!en) begin
            m_y = 0; m_ov = 0; m_hold = 0;
        end else if (in_valid && m_hold == 0) begin
            m_y    = decode(int'(mode), int'(d_in));
            m_ov   = 1;
            m_hold = (mode == 2'd2) ? HOLD : 0;
        end else begin
            m_ov = 0;
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) m_y = 0;
            end
        end
    end

    task automatic tick(input bit e, input bit v, input logic [1:0] m, input logic [3:0] d);
        en = e; in_valid = v; mode = m; d_in = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (y_out !== 16'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out y_out=%h out_valid=%b expected 0000/0", y_out, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b1 || y_out !== 16'h0) begin
            errors++; $display("FAIL reset_idle in_ready=%b y_out=%h expected 1/0000", in_ready, y_out);
        end
    endtask

    task automatic test_onehot_hold();
        tick(1, 1, 0, 4'hA);
        checks++;
        if (y_out !== 16'h0400 || out_valid !== 1'b1) begin
            errors++; $display("FAIL onehot_accept y_out=%h out_valid=%b expected 0400/1", y_out, out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            checks++;
            if (y_out !== 16'h0400 || out_valid !== 1'b0) begin
                errors++; $display("FAIL onehot_held[%0d] y_out=%h out_valid=%b expected 0400/0", i, y_out, out_valid);
            end
        end
    endtask

    task automatic test_therm_onecold();
        logic [1:0]  md[4]  = '{2'd1, 2'd1, 2'd3, 2'd1};
        logic [3:0]  dd[4]  = '{4'd3, 4'd15, 4'd0, 4'd0};
        logic [15:0] ex[4]  = '{16'h000F, 16'hFFFF, 16'hFFFE, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, md[i], dd[i]);
            checks++;
            if (y_out !== ex[i] || out_valid !== 1'b1) begin
                errors++; $display("FAIL therm_onecold[%0d] y_out=%h out_valid=%b expected %h/1", i, y_out, out_valid, ex[i]);
            end
        end
    endtask

    task automatic test_pulse();
        tick(1, 1, 2, 4'd2);
        for (int k = 1; k <= HOLD; k++) begin
            checks++;
            if (y_out !== 16'h0004 || in_ready !== 1'b0 || out_valid !== (k == 1)) begin
                errors++; $display("FAIL pulse_hold[%0d] y_out=%h in_ready=%b out_valid=%b expected 0004/0/%b",
                                   k, y_out, in_ready, out_valid, k == 1);
            end
            tick(1, k == 2, 0, 4'd9);
        end
        checks++;
        if (y_out !== 16'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL pulse_end y_out=%h in_ready=%b out_valid=%b expected 0000/1/0", y_out, in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            tick(1, 1, 0, 4'(i));
            checks++;
            if (y_out !== (16'h1 << i) || out_valid !== 1'b1) begin
                errors++; $display("FAIL b2b[%0d] y_out=%h out_valid=%b expected %h/1", i, y_out, out_valid, 16'h1 << i);
            end
        end
        tick(1, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_strobe_end out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_en_drop();
        tick(1, 1, 2, 4'd5);
        tick(1, 0, 2, 4'd5);
        tick(0, 1, 2, 4'd5);
        checks++;
        if (y_out !== 16'h0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL en_drop y_out=%h out_valid=%b in_ready=%b expected 0000/0/0", y_out, out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 2'd3, 4'd5);
            checks++;
            if (y_out !== 16'h0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL en_restore[%0d] y_out=%h in_ready=%b expected 0000/1", i, y_out, in_ready);
            end
        end
        tick(1, 1, 3, 4'd1);
        tick(0, 0, 3, 4'd1);
        checks++;
        if (y_out !== 16'h0) begin
            errors++; $display("FAIL onecold_disable y_out=%h expected 0000", y_out);
        end
    endtask

    task automatic test_reset_hold();
        d_in3 = 3'd5;
        tick(1, 1, 2, 4'd6);
        tick(1, 0, 2, 4'd6);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (y_out !== 16'h0 || y_out3 !== 8'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_hold y_out=%h y_out3=%h out_valid=%b expected 0/0/0", y_out, y_out3, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        d_in3 = 3'd7;
        tick(1, 1, 0, 4'd0);
        checks++;
        if (y_out !== 16'h0001 || y_out3 !== 8'h80 || out_valid3 !== 1'b1) begin
            errors++; $display("FAIL reset_reaccept y_out=%h y_out3=%h out_valid3=%b expected 0001/80/1", y_out, y_out3, out_valid3);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            checks++;
            if (longint'(y_out) !== m_y || out_valid !== m_ov || in_ready !== (en && m_hold == 0)) begin
                errors++; $display("FAIL random[%0d] y_out=%h out_valid=%b in_ready=%b expected %h/%b/%b",
                                   i, y_out, out_valid, in_ready, m_y[15:0], m_ov, en && m_hold == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_onehot_hold();
        test_therm_onecold();
        test_pulse();
        test_back_to_back();
        test_en_drop();
        test_reset_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
